// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state/owner encodings and counter width for the memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int CNT_W = 3;
  typedef enum logic {ARB_IDLE, ARB_ACC} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between instruction fetch
// and data access, one fixed-latency access at a time with a one-cycle ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m
);
  arb_state_e       r_state, w_state_nx;
  owner_e           r_owner, w_win;
  logic [CNT_W-1:0] r_cnt, r_starve;
  logic             w_ack, w_grant;

  // Data is older in the pipeline, so it wins unless fetch has been starved long enough.
  function automatic owner_e pick_owner(input logic f_req, input logic m_req,
                                        input logic [CNT_W-1:0] starve);
    return (m_req && !(f_req && starve == CNT_W'(STARVE_MAX))) ? OWN_D : OWN_IF;
  endfunction

  always_comb begin
    w_ack      = (r_state == ARB_ACC) && (r_cnt == '0);
    w_grant    = ((r_state == ARB_IDLE) || w_ack) && (if_req || d_req);
    w_win      = pick_owner(if_req, d_req, r_starve);
    w_state_nx = w_grant ? ARB_ACC : w_ack ? ARB_IDLE : r_state;
    if_ack     = w_ack && (r_owner == OWN_IF);
    d_ack      = w_ack && (r_owner == OWN_D);
    if_rdata   = mem_rdata;
    d_rdata    = mem_rdata;
    stall_f    = if_req && !if_ack;
    stall_m    = d_req && !d_ack;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r_cnt     <= '0;
      r_owner   <= OWN_IF;
    end else if (w_grant) begin
      mem_en    <= 1'b1;
      mem_we    <= (w_win == OWN_D) && d_we;
      mem_addr  <= (w_win == OWN_D) ? d_addr : if_addr;
      mem_wdata <= (w_win == OWN_D) ? d_wdata : '0;
      r_cnt     <= CNT_W'(WAIT_CYCLES);
      r_owner   <= w_win;
    end else begin
      mem_we <= 1'b0;
      if (w_ack) mem_en <= 1'b0;
      else if (r_state == ARB_ACC) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Counts data grants that bypassed a waiting fetch; any cycle without a fetch request clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_starve <= '0;
    else if (!if_req) r_starve <= '0;
    else if (w_grant)
      r_starve <= (w_win == OWN_IF) ? '0 :
                  (r_starve == CNT_W'(STARVE_MAX)) ? r_starve : r_starve + CNT_W'(1);
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic [15:0] if_rdata, d_rdata;
  logic        if_ack, d_ack;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_f, stall_m;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] mem [0:255];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_CYCLES(1), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    next_cycle();
    pl_en = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] exp, input string tag);
    d_req = 1'b1; d_we = 1'b0; d_addr = a;
    @(negedge clk);
    chk({tag, "_c0_stall_m"}, 32'(stall_m), 1);
    chk({tag, "_c0_mem_en"}, 32'(mem_en), 0);
    next_cycle();
    @(negedge clk);
    chk({tag, "_c1_mem_en"}, 32'(mem_en), 1);
    chk({tag, "_c1_mem_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_c1_d_ack"}, 32'(d_ack), 0);
    chk({tag, "_c1_stall_m"}, 32'(stall_m), 1);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    chk({tag, "_c2_mem_en"}, 32'(mem_en), 1);
    chk({tag, "_c2_d_ack"}, 32'(d_ack), 1);
    chk({tag, "_c2_d_rdata"}, 32'(d_rdata), 32'(exp));
    next_cycle();
    @(negedge clk);
    chk({tag, "_c3_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_c3_d_ack"}, 32'(d_ack), 0);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    next_cycle();
    preload(8'h40, 16'hBEEF);
    preload(8'h20, 16'hCAFE);
    preload(8'h30, 16'h7777);
    preload(8'h10, 16'h0000);
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 0);
    rst_n = 1'b1;
    next_cycle();

    // single load
    do_load(16'h0040, 16'hBEEF, "ld1");

    // single store then read back
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
    @(negedge clk);
    chk("st_c0_mem_we", 32'(mem_we), 0);
    next_cycle();
    @(negedge clk);
    chk("st_c1_mem_we", 32'(mem_we), 1);
    chk("st_c1_mem_wdata", 32'(mem_wdata), 32'h1234);
    next_cycle();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("st_c2_mem_we", 32'(mem_we), 0);
    chk("st_c2_d_ack", 32'(d_ack), 1);
    next_cycle();
    @(negedge clk);
    chk("st_c3_mem_en", 32'(mem_en), 0);
    next_cycle();
    do_load(16'h0010, 16'h1234, "rb");

    // simultaneous requests: data first, fetch follows without a bubble
    if_req = 1'b1; if_addr = 16'h0020; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    next_cycle();
    @(negedge clk);
    chk("sim_c1_mem_addr", 32'(mem_addr), 32'h0040);
    chk("sim_c1_stall_f", 32'(stall_f), 1);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    chk("sim_c2_d_ack", 32'(d_ack), 1);
    chk("sim_c2_if_ack", 32'(if_ack), 0);
    next_cycle();
    @(negedge clk);
    chk("sim_c3_mem_en", 32'(mem_en), 1);
    chk("sim_c3_mem_addr", 32'(mem_addr), 32'h0020);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    chk("sim_c4_if_ack", 32'(if_ack), 1);
    chk("sim_c4_if_rdata", 32'(if_rdata), 32'hCAFE);
    next_cycle();
    @(negedge clk);
    chk("sim_c5_mem_en", 32'(mem_en), 0);
    next_cycle();

    // starvation: D D D IF D D
    d_we = 1'b0; d_addr = 16'h0040; if_addr = 16'h0020;
    for (int c = 0; c < 14; c++) begin
      if_req = (c < 8);
      d_req  = (c < 12);
      @(negedge clk);
      chk($sformatf("stv_c%0d_d_ack", c), 32'(d_ack),
          32'((c == 2) || (c == 4) || (c == 6) || (c == 10) || (c == 12)));
      chk($sformatf("stv_c%0d_if_ack", c), 32'(if_ack), 32'(c == 8));
      if (c == 2) chk("stv_c2_stall_m", 32'(stall_m), 0);
      if (c == 7) chk("stv_c7_mem_addr", 32'(mem_addr), 32'h0020);
      next_cycle();
    end
    @(negedge clk);
    chk("stv_end_mem_en", 32'(mem_en), 0);
    next_cycle();

    // flushed fetch still completes
    if_req = 1'b1; if_addr = 16'h0020;
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    chk("fl_c1_mem_en", 32'(mem_en), 1);
    next_cycle();
    @(negedge clk);
    chk("fl_c2_if_ack", 32'(if_ack), 1);
    next_cycle();
    @(negedge clk);
    chk("fl_c3_mem_en", 32'(mem_en), 0);
    chk("fl_c3_if_ack", 32'(if_ack), 0);
    next_cycle();

    // reset during the first cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h5555;
    next_cycle();
    chk("rs_c1_mem_we", 32'(mem_we), 1);
    rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("rs_mem_we", 32'(mem_we), 0);
    chk("rs_mem_en", 32'(mem_en), 0);
    chk("rs_d_ack", 32'(d_ack), 0);
    next_cycle();
    @(negedge clk);
    chk("rs_hold_d_ack", 32'(d_ack), 0);
    rst_n = 1'b1;
    next_cycle();
    do_load(16'h0030, 16'h7777, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
